// File: rtl/duck_hit_detector.sv
// Shot resolution for the duck game: trigger sync/edge detect, per-frame hit scan,
// BCD score and shot bookkeeping. Optional macro DUCK_PIXEL_MASK_EN ignores transparent pixels.
module duck_hit_detector #(
    parameter int         H_ACTIVE        = 640,
    parameter int         V_ACTIVE        = 480,
    parameter int         COOLDOWN_FRAMES = 8,
    parameter int         SHOTS_PER_ROUND = 3,
    parameter logic [5:0] TRANSPARENT     = 6'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       trigger,
    input  logic [9:0] cross_x,
    input  logic [9:0] cross_y,
    input  logic       duck_draw,
    input  logic [5:0] duck_data,
    output logic       collision,
    output logic [7:0] score,
    output logic [1:0] shots_left,
    output logic       round_over,
    output logic       busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT     = 3'd1;
    localparam logic [2:0] S_SCAN     = 3'd2;
    localparam logic [2:0] S_REPORT   = 3'd3;
    localparam logic [2:0] S_COOLDOWN = 3'd4;

    localparam logic [9:0] H_LIM   = 10'(H_ACTIVE);
    localparam logic [9:0] V_LIM   = 10'(V_ACTIVE);
    localparam logic [3:0] CD_LAST = 4'(COOLDOWN_FRAMES - 1);
    localparam logic [1:0] RELOAD  = 2'(SHOTS_PER_ROUND);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       trig_prev_q, trig_prev_d;
    logic       shot_q, shot_d;
    logic [9:0] h_d_q, h_d_d;
    logic [9:0] v_d_q, v_d_d;
    logic [2:0] state_q, state_d;
    logic       hit_q, hit_d;
    logic [3:0] cd_cnt_q, cd_cnt_d;
    logic [7:0] score_q, score_d;
    logic [1:0] shots_q, shots_d;

    logic frame_start, frame_end, cross_visible, pixel_opaque, coincide;

`ifdef DUCK_PIXEL_MASK_EN
    assign pixel_opaque = (duck_data != TRANSPARENT);
`else
    logic unused_pixel;
    assign pixel_opaque = 1'b1;
    assign unused_pixel = ^{duck_data, TRANSPARENT};
`endif

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99)
            r = v;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    always_comb begin
        sync1_d     = trigger;
        sync2_d     = sync1_q;
        trig_prev_d = sync2_q;
        shot_d      = sync2_q & ~trig_prev_q;
        h_d_d       = hcount;
        v_d_d       = vcount;

        frame_start   = (hcount == 10'd0) && (vcount == 10'd0);
        frame_end     = (hcount == 10'd0) && (vcount == V_LIM);
        cross_visible = (cross_x < H_LIM) && (cross_y < V_LIM);
        // duck_draw is one cycle late, so it lines up with the delayed counters
        coincide      = duck_draw && pixel_opaque && cross_visible &&
                        (h_d_q == cross_x) && (v_d_q == cross_y);
    end

    always_comb begin
        state_d  = state_q;
        hit_d    = hit_q;
        cd_cnt_d = cd_cnt_q;
        score_d  = score_q;
        shots_d  = shots_q;
        case (state_q)
            S_IDLE: begin
                if (shot_q) begin
                    shots_d = shots_q - 2'd1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (frame_start) begin
                    hit_d   = 1'b0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (coincide)
                    hit_d = 1'b1;
                if (frame_end)
                    state_d = S_REPORT;
            end
            S_REPORT: begin
                if (hit_q) begin
                    score_d = bcd_inc(score_q);
                    shots_d = RELOAD;
                end else if (shots_q == 2'd0) begin
                    shots_d = RELOAD;
                end
                cd_cnt_d = 4'd0;
                state_d  = S_COOLDOWN;
            end
            S_COOLDOWN: begin
                if (frame_end) begin
                    if (cd_cnt_q == CD_LAST)
                        state_d = S_IDLE;
                    else
                        cd_cnt_d = cd_cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            trig_prev_q <= 1'b0;
            shot_q      <= 1'b0;
            h_d_q       <= 10'd0;
            v_d_q       <= 10'd0;
            state_q     <= S_IDLE;
            hit_q       <= 1'b0;
            cd_cnt_q    <= 4'd0;
            score_q     <= 8'h00;
            shots_q     <= RELOAD;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            trig_prev_q <= trig_prev_d;
            shot_q      <= shot_d;
            h_d_q       <= h_d_d;
            v_d_q       <= v_d_d;
            state_q     <= state_d;
            hit_q       <= hit_d;
            cd_cnt_q    <= cd_cnt_d;
            score_q     <= score_d;
            shots_q     <= shots_d;
        end
    end

    assign collision  = (state_q == S_REPORT) && hit_q;
    assign round_over = (state_q == S_REPORT) && !hit_q && (shots_q == 2'd0);
    assign busy       = (state_q != S_IDLE);
    assign score      = score_q;
    assign shots_left = shots_q;

endmodule

// File: tb/tb_duck_hit_detector.sv
// Directed bench for duck_hit_detector on a reduced 12x8 raster (8x6 visible);
// a bench-side sprite model drives the registered duck_draw/duck_data stream.
module tb_duck_hit_detector;

    localparam int HA = 8;
    localparam int VA = 6;
    localparam int HT = 12;
    localparam int VT = 8;
    localparam int CD = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hcount, vcount, cross_x, cross_y;
    logic       trigger, duck_draw;
    logic [5:0] duck_data;
    logic       collision, round_over, busy;
    logic [7:0] score;
    logic [1:0] shots_left;

    int dx = 2, dy = 1;
    int frame_no = 0;
    int col_cnt = 0, ro_cnt = 0, both_cnt = 0;
    int col_h = -1, col_v = -1, col_frame = 0, col_gap = 0;
    int n_checks = 0, n_pass = 0, n_fail = 0;
    int shot_no = 0;

    always #5 clk = ~clk;

    duck_hit_detector #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .COOLDOWN_FRAMES(CD),
        .SHOTS_PER_ROUND(3), .TRANSPARENT(6'h00)
    ) dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .trigger(trigger), .cross_x(cross_x), .cross_y(cross_y),
        .duck_draw(duck_draw), .duck_data(duck_data),
        .collision(collision), .score(score), .shots_left(shots_left),
        .round_over(round_over), .busy(busy)
    );

    // raster generator plus registered sprite stream (describes the pixel just left)
    initial begin
        hcount = 10'd0; vcount = 10'd0; duck_draw = 1'b0; duck_data = 6'h00;
        forever begin
            @(negedge clk);
            duck_draw = (int'(hcount) >= dx) && (int'(hcount) < dx + 4) &&
                        (int'(vcount) >= dy) && (int'(vcount) < dy + 3);
            duck_data = (int'(hcount) == dx && int'(vcount) == dy) ? 6'h00 : 6'h2A;
            if (int'(hcount) == HT - 1) begin
                hcount = 10'd0;
                vcount = (int'(vcount) == VT - 1) ? 10'd0 : vcount + 10'd1;
            end else begin
                hcount = hcount + 10'd1;
            end
            if (hcount == 10'd0 && int'(vcount) == VA)
                frame_no++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (collision) begin
                col_cnt++;
                col_h = int'(hcount);
                col_v = int'(vcount);
                col_gap = frame_no - col_frame;
                col_frame = frame_no;
            end
            if (round_over) ro_cnt++;
            if (collision && round_over) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pos(input int h, input int v);
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!(int'(hcount) == h && int'(vcount) == v) && n < 400);
    endtask

    task automatic shoot(output logic [1:0] mid, output int dcol, output int dro);
        int c0 = col_cnt;
        int r0 = ro_cnt;
        int n = 0;
        @(negedge clk); trigger = 1'b1;
        repeat (3) @(negedge clk);
        trigger = 1'b0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        check("shot_busy_rise", busy, 1'b1);
        mid = shots_left;
        n = 0;
        while (busy && n < 2000) begin @(negedge clk); n++; end
        check("shot_busy_fall", busy, 1'b0);
        repeat (2) @(negedge clk);
        dcol = col_cnt - c0;
        dro  = ro_cnt - r0;
        shot_no++;
        $display("shot %0d: cross=(%0d,%0d) mid_shots=%0d collisions=%0d round_over=%0d score=%02h shots_left=%0d",
                 shot_no, cross_x, cross_y, mid, dcol, dro, score, shots_left);
    endtask

    initial begin
        logic [1:0] mid;
        int dc, dr, c0, n, exp_score;
        logic [7:0] exp_bcd;

        reset = 1'b0; trigger = 1'b0; cross_x = 10'd4; cross_y = 10'd2;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_collision", collision, 1'b0);
        check("rst_round_over", round_over, 1'b0);
        check("rst_score", score, 8'h00);
        check("rst_shots", shots_left, 2'd3);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 1'b0);

        // opaque hit
        shoot(mid, dc, dr);
        check("hit_mid_shots", mid, 2'd2);
        check("hit_collision", dc, 1);
        check("hit_round_over", dr, 0);
        check("hit_score", score, 8'h01);
        check("hit_shots", shots_left, 2'd3);
        check("hit_col_h", col_h, 0);
        check("hit_col_v", col_v, VA);

        // three misses exhaust the round
        cross_x = 10'd0; cross_y = 10'd5;
        for (int i = 0; i < 3; i++) begin
            shoot(mid, dc, dr);
            check("miss_mid_shots", mid, 2 - i);
            check("miss_collision", dc, 0);
            check("miss_round_over", dr, (i == 2) ? 1 : 0);
        end
        check("miss_shots_reload", shots_left, 2'd3);
        check("miss_score", score, 8'h01);

        // crosshair in blanking, duck also drawn there: never a hit
        dx = 8; cross_x = 10'd9; cross_y = 10'd2;
        shoot(mid, dc, dr);
        check("oor_collision", dc, 0);
        check("oor_round_over", dr, 0);
        check("oor_shots", shots_left, 2'd2);

        // transparent corner pixel
        dx = 2; cross_x = 10'd2; cross_y = 10'd1;
        shoot(mid, dc, dr);
        check("mask_mid_shots", mid, 2'd1);
`ifdef DUCK_PIXEL_MASK_EN
        check("mask_collision", dc, 0);
        check("mask_shots", shots_left, 2'd1);
        exp_score = 1;
`else
        check("mask_collision", dc, 1);
        check("mask_shots", shots_left, 2'd3);
        exp_score = 2;
`endif
        check("mask_score", score, 8'(exp_score));

        // trigger every frame: only every CD+1 frames resolves
        cross_x = 10'd4; cross_y = 10'd2;
        c0 = col_cnt;
        for (int f = 0; f < 9; f++) begin
            wait_pos(4, VA);
            @(negedge clk); trigger = 1'b1;
            repeat (3) @(negedge clk);
            trigger = 1'b0;
        end
        n = 0;
        while (busy && n < 3000) begin @(negedge clk); n++; end
        check("spacing_idle", busy, 1'b0);
        check("spacing_count", col_cnt - c0, 3);
        check("spacing_gap", col_gap, CD + 1);
        check("spacing_score", score, 8'(exp_score + 3));
        $display("spacing: collisions=%0d gap=%0d frames score=%02h", col_cnt - c0, col_gap, score);

        // reset in the middle of a scanned frame, after the hit was seen
        @(negedge clk); trigger = 1'b1;
        repeat (3) @(negedge clk);
        trigger = 1'b0;
        n = 0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        check("rstmid_busy_pre", busy, 1'b1);
        wait_pos(0, 0);
        wait_pos(0, 4);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_score", score, 8'h00);
        check("rstmid_shots", shots_left, 2'd3);
        check("rstmid_collision", collision, 1'b0);
        check("rstmid_round_over", round_over, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        c0 = col_cnt;
        wait_pos(0, VA);
        repeat (4) @(negedge clk);
        check("rstmid_no_pulse", col_cnt - c0, 0);
        check("rstmid_idle", busy, 1'b0);
        $display("reset mid-scan: score=%02h shots_left=%0d busy=%0d", score, shots_left, busy);

        // BCD carry and saturation over 100 hits
        for (int i = 1; i <= 100; i++) begin
            shoot(mid, dc, dr);
            exp_bcd = (i > 99) ? 8'h99 : {4'(i / 10), 4'(i % 10)};
            check("bcd_score", score, exp_bcd);
            check("bcd_collision", dc, 1);
        end
        check("exclusive_pulses", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/duck_hit_detector.md
# duck_hit_detector

Shot-resolution block for the duck game. It consumes the per-pixel `draw`/`data` stream produced by the duck sprite drawer, together with the crosshair position and the trigger button. Once per video frame it decides whether a shot landed on an opaque duck pixel. It returns the one-cycle `collision` pulse that the drawer uses to respawn the duck, and it maintains the BCD score and the remaining-shots count.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines; frame end is the first cycle of line `V_ACTIVE`.
- `COOLDOWN_FRAMES`, 8: frames ignored after each resolved shot (range 1–15).
- `SHOTS_PER_ROUND`, 3: shots per round (range 1–3).
- `TRANSPARENT`, 6'h00: sprite colour treated as background.

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: asynchronous, active-low.
- `hcount` in 10: current pixel column.
- `vcount` in 10: current line.
- `trigger` in 1: raw, asynchronous fire button.
- `cross_x` in 10: crosshair column.
- `cross_y` in 10: crosshair line.
- `duck_draw` in 1: duck pixel valid; registered, so it refers to the previous cycle's `hcount`/`vcount`.
- `duck_data` in 6: duck pixel colour, aligned with `duck_draw`.
- `collision` out 1: one-cycle hit pulse.
- `score` out 8: two BCD digits, {tens, units}.
- `shots_left` out 2: shots remaining in the current round.
- `round_over` out 1: one-cycle pulse when the last shot misses.
- `busy` out 1: high in every state except IDLE.

## Operation
- Trigger input path:
  - `trigger` passes through a 2-FF synchronizer.
  - A rising edge of the synchronized signal is an accepted shot only in IDLE.
  - Edges in any other state are dropped.
- Pixel alignment: `hcount`/`vcount` are delayed one cycle (`h_d`, `v_d`) and compared with `cross_x`/`cross_y` against the registered duck stream.
- FSM (states IDLE, WAIT_FRAME, SCAN, REPORT, COOLDOWN):
  - IDLE: on an accepted shot, decrement `shots_left` and go to WAIT_FRAME.
  - WAIT_FRAME: on `hcount==0 && vcount==0`, clear `hit` and go to SCAN.
  - SCAN: on the cycle where `h_d==cross_x && v_d==cross_y && duck_draw`, set `hit`. On `hcount==0 && vcount==V_ACTIVE`, go to REPORT.
  - REPORT (exactly one cycle):
    - If `hit`: `collision`=1, score BCD +1, `shots_left` reloads to `SHOTS_PER_ROUND`.
    - Else if `shots_left==0`: `round_over`=1, `shots_left` reloads.
    - Then go to COOLDOWN with `cd_cnt`=0.
  - COOLDOWN: each frame end increments `cd_cnt`. When `cd_cnt==COOLDOWN_FRAMES-1` at a frame end, go to IDLE.
- Score arithmetic:
  - When units==9, units goes to 0 and tens increments.
  - The score saturates at 8'h99; a hit at 99 still pulses `collision`.
- A crosshair outside the visible area (`cross_x>=H_ACTIVE` or `cross_y>=V_ACTIVE`) can never hit.
- `hit` is sticky within a frame; multiple coincidences still produce one pulse.

## Timing
- Reset values:
  - State IDLE.
  - `collision`=0, `round_over`=0, `busy`=0.
  - `score`=8'h00.
  - `shots_left`=`SHOTS_PER_ROUND`.
  - Synchronizer FFs, `hit` and `cd_cnt` all 0.
- Reset asserted mid-shot: the shot is abandoned, no pulse is emitted, and the score is cleared.
- Trigger latency: 2 synchronizer cycles plus 1 edge-detect cycle, then the IDLE→WAIT_FRAME transition on the next edge.
- A shot accepted during line 0, pixel 0 waits for the next frame's start; frames are never partially scanned.
- `collision` is high exactly on the REPORT cycle, which is the cycle after `hcount==0 && vcount==V_ACTIVE`. The duck drawer sees it before the next visible line.
- `score` and `shots_left` update on the REPORT cycle; both are registered.
- `round_over` and `collision` are mutually exclusive.
- Minimum spacing between two resolved shots: `COOLDOWN_FRAMES`+1 frames.

## Configuration
- `DUCK_PIXEL_MASK_EN`:
  - Defined: a hit additionally requires `duck_data != TRANSPARENT`, so transparent corners of the sprite box are misses.
  - Undefined: any `duck_draw` pixel (the full 46×40 bounding box) counts as a hit.

## Test plan
- Opaque hit:
  - Stimulus: duck at (300,150), crosshair (320,170) with opaque data, one trigger pulse.
  - Response: one `collision` pulse at the frame end, `score`=8'h01, `shots_left`=3.
- Miss:
  - Stimulus: crosshair (10,10), three shots spaced by cooldown.
  - Response: `shots_left` goes 2→1→0; on the third REPORT, `round_over`=1, `shots_left`=3, no `collision`.
- Mask:
  - Stimulus: crosshair on a pixel with `duck_draw`=1, `duck_data`=6'h00.
  - Response with macro: miss. Response without macro: hit.
- Cooldown and BCD:
  - Stimulus: trigger held toggling every frame.
  - Response: shots are resolved only every 9 frames. Starting from `score`=8'h09, a hit gives 8'h10. Starting from 8'h99, a hit stays 8'h99 and still pulses `collision`.
- Async reset mid-SCAN:
  - Stimulus: `reset`=0 for 3 cycles.
  - Response: all outputs return to reset values immediately; no `collision` pulse at the following frame end.
